// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Results land in shadow registers at start and commit to HI/LO on the last busy edge.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] MDUresult,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, hi_sh_q, hi_sh_d, lo_sh_q, lo_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending, start, is_mul, sdiv, div0;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   mag_a, mag_b, q_mag, r_mag, quo, rem;
  assign pending = cnt_q != '0;
  assign start   = !pending && MDUop >= 4'd1 && MDUop <= 4'd4;
  assign is_mul  = MDUop == 4'd1 || MDUop == 4'd2;
  assign sdiv    = MDUop == 4'd3;
  assign div0    = SrcB == '0;
  assign prod_s  = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
  assign prod_u  = {32'b0, SrcA} * {32'b0, SrcB};
  // Signed divide works on magnitudes; negating 0x80000000 wraps to itself, which
  // is exactly the required quotient for 0x80000000 / -1.
  assign mag_a   = (sdiv && SrcA[31]) ? -SrcA : SrcA;
  assign mag_b   = (sdiv && SrcB[31]) ? -SrcB : SrcB;
  assign q_mag   = div0 ? '0 : mag_a / mag_b;
  assign r_mag   = div0 ? '0 : mag_a % mag_b;
  assign quo     = (sdiv && (SrcA[31] ^ SrcB[31])) ? -q_mag : q_mag;
  assign rem     = (sdiv && SrcA[31]) ? -r_mag : r_mag;
  always_comb begin
    cnt_d   = start ? (is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES)) :
              pending ? cnt_q - CW'(1) : cnt_q;
    hi_sh_d = !start ? hi_sh_q : MDUop == 4'd1 ? prod_s[63:32] :
              MDUop == 4'd2 ? prod_u[63:32] : div0 ? hi_q : rem;
    lo_sh_d = !start ? lo_sh_q : MDUop == 4'd1 ? prod_s[31:0] :
              MDUop == 4'd2 ? prod_u[31:0] : div0 ? lo_q : quo;
    hi_d    = (cnt_q == CW'(1)) ? hi_sh_q : (!pending && MDUop == 4'd5) ? SrcA : hi_q;
    lo_d    = (cnt_q == CW'(1)) ? lo_sh_q : (!pending && MDUop == 4'd6) ? SrcA : lo_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      hi_sh_q <= '0;
      lo_sh_q <= '0;
      cnt_q   <= '0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_sh_q <= hi_sh_d;
      lo_sh_q <= lo_sh_d;
      cnt_q   <= cnt_d;
    end
  end
  assign Busy      = start | pending;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign MDUresult = (MDUop == 4'd7) ? hi_q : (MDUop == 4'd8) ? lo_q : '0;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu; a cycle-level model queues expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUop;
  logic [31:0] SrcA, SrcB, MDUresult, HI, LO;
  logic        Busy;
  typedef struct packed {
    logic        busy;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_until = -1;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDUop(MDUop), .SrcA(SrcA), .SrcB(SrcB),
    .MDUresult(MDUresult), .Busy(Busy), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("busy", {31'b0, Busy}, {31'b0, e.busy});
      cmp("mduresult", MDUresult, e.res);
      cmp("hi", HI, e.hi);
      cmp("lo", LO, e.lo);
    end
  end
  // Architectural result of an MDU op, computed with wide integer arithmetic.
  task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    if (op == 4'd1) begin
      p = 64'(sa * sb2);
      p_hi = p[63:32]; p_lo = p[31:0];
    end else if (op == 4'd2) begin
      p = {32'b0, a} * {32'b0, b};
      p_hi = p[63:32]; p_lo = p[31:0];
    end else if (b == 0) begin
      p_hi = m_hi; p_lo = m_lo;
    end else if (op == 4'd3) begin
      q = sa / sb2; r = sa % sb2;
      p_hi = r[31:0]; p_lo = q[31:0];
    end else begin
      p_hi = a % b; p_lo = a / b;
    end
  endtask
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic bz, st;
    exp_t e;
    MDUop = op; SrcA = a; SrcB = b;
    bz = cyc <= busy_until;
    st = !bz && op >= 4'd1 && op <= 4'd4;
    e.busy = st || bz;
    e.res  = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'h0;
    e.hi   = m_hi;
    e.lo   = m_lo;
    sb.push_back(e);
    if (st) begin
      compute(op, a, b);
      busy_until = cyc + ((op <= 4'd2) ? MC : DC);
    end else if (!bz && op == 4'd5) m_hi = a;
    else if (!bz && op == 4'd6) m_lo = a;
    if (bz && cyc == busy_until) begin
      m_hi = p_hi; m_lo = p_lo;
    end
    @(posedge clk); #1;
    cyc++;
  endtask
  task automatic rst_step();
    reset = 1'b1;
    MDUop = '0; SrcA = '0; SrcB = '0;
    m_hi = '0; m_lo = '0; busy_until = -1;
    sb.push_back('{busy: 1'b0, res: 32'h0, hi: 32'h0, lo: 32'h0});
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, '0, '0);
  endtask
  function automatic logic [31:0] pick();
    logic [31:0] edges [6];
    edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
    return ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
  endfunction
  initial begin
    reset = 1'b1; MDUop = '0; SrcA = '0; SrcB = '0;
    @(posedge clk); #1;
    rst_step();
    step(4'd1, 32'hFFFFFFFF, 32'd2); idle(MC + 1);
    step(4'd2, 32'hFFFFFFFF, 32'd2); idle(MC + 1);
    step(4'd3, -32'sd7, 32'd2); idle(DC + 1);
    step(4'd4, 32'd7, 32'd2); idle(DC + 1);
    rst_step();
    step(4'd5, 32'h12345678, '0);
    step(4'd8, '0, '0);
    step(4'd7, '0, '0);
    step(4'd3, 32'd5, 32'd0); idle(DC + 1);
    step(4'd8, '0, '0);
    step(4'd1, 32'd3, 32'd4); idle(2);
    step(4'd7, '0, '0);
    step(4'd6, 32'hDEADBEEF, '0);
    step(4'd3, 32'd100, 32'd7);
    idle(1);
    step(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(MC + 1);
    step(4'd3, 32'd1000, 32'd3); idle(3);
    rst_step();
    idle(DC + 2);
    step(4'd3, 32'h80000000, 32'hFFFFFFFF); idle(DC + 1);
    step(4'd1, 32'h80000000, 32'h80000000); idle(MC + 1);
    step(4'd4, 32'h80000000, 32'hFFFFFFFF); idle(DC + 1);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) rst_step();
      step(4'($urandom_range(0, 15)), pick(), pick());
    end
    idle(DC + 2);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage MIPS pipeline, placed in E beside the ALU. It takes forwarded E-stage operands and executes mult/multu/div/divu over a fixed multi-cycle latency. It also owns the architectural HI/LO registers: it writes them for mthi/mtlo and drives their value for mfhi/mflo into EX_DM as the E-stage result. Its busy output feeds the hazard unit, which stalls any MDU instruction in D while an operation is pending.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- MDUop  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 treated as none
- SrcA  in  32  forwarded rs value
- SrcB  in  32  forwarded rt value
- MDUresult  out  32  HI for mfhi, LO for mflo, else 0 (combinational)
- Busy  out  1  (start condition) | busy_reg; consumed by HAZARD
- HI  out  32  architectural HI
- LO  out  32  architectural LO

## Operation
- State: HI, LO, HI_shadow, LO_shadow, cnt (width fits max(MULT_CYCLES, DIV_CYCLES)), busy_reg = (cnt != 0).
- Reset (async): HI = LO = shadows = 0, cnt = 0; so Busy = 0 and MDUresult = 0 with MDUop = none.
- Start condition: MDUop ∈ {1..4} and busy_reg = 0. On that edge:
  - the result is computed from SrcA/SrcB and stored in the shadows;
  - cnt loads MULT_CYCLES or DIV_CYCLES.
- Arithmetic:
  - mult: signed 32×32 → 64; HI = [63:32], LO = [31:0].
  - multu: the same, unsigned.
  - div: LO = signed quotient, truncated toward zero; HI = remainder, sign of dividend.
  - divu: unsigned quotient and remainder.
  - 0x80000000 div 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (SrcB = 0): the shadows are loaded with the current HI/LO, so the commit leaves HI/LO unchanged; full DIV_CYCLES busy still applies.
- Count: each edge with cnt ≠ 0 decrements cnt. On the edge where cnt = 1, HI ← HI_shadow and LO ← LO_shadow.
- mthi/mtlo with busy_reg = 0: HI (resp. LO) ← SrcA on the edge; no busy.
- Any MDUop in E while busy_reg = 1 is ignored: no start, no write, and MDUresult reads the old HI/LO. The hazard unit guarantees this does not occur.
- mfhi/mflo: pure reads; no state change.

## Timing
- Start edge ends cycle 0. busy_reg is high in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO change at the edge ending cycle N; the new value is visible from cycle N+1. An mfhi in E during cycle N+1 returns the new HI.
- Busy is high in cycle 0 too, via the combinational start term, so a following MDU op in D stalls immediately.
- Busy falls in cycle N+1 unless a new start occurs in cycle N+1.
- Back-to-back: a start is accepted in cycle N+1. During 1..N, HI/LO hold their pre-start values.
- mthi/mtlo: a write at the edge ending cycle 0 is visible to MDUresult in cycle 1.
- Reset asserted mid-operation: cnt → 0 and Busy → 0 immediately (async); the pending result is discarded and HI = LO = 0.
- Reset released: normal operation begins from the first rising edge after deassertion.

## Test plan
- mult 0xFFFFFFFF × 2 -> Busy high for cycles 0..5, HI = 0xFFFFFFFF and LO = 0xFFFFFFFE from cycle 6. multu with the same operands -> HI = 0x00000001, LO = 0xFFFFFFFE.
- div -7 / 2 -> after 10 busy cycles, LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). divu 7 / 2 -> LO = 3, HI = 1.
- mthi 0x12345678, then mflo, then mfhi -> MDUresult = 0 (initial LO), then 0x12345678. Divide by zero afterwards -> HI stays 0x12345678 and LO stays 0 after 10 busy cycles.
- During busy:
  - mfhi in cycle 3 of a mult -> returns the old HI.
  - mtlo in cycle 3 -> ignored.
  - div in cycle 3 -> not started.
  - A new mult in cycle 6 -> accepted, Busy stays high without a gap.
- Reset asserted in cycle 4 of a div -> Busy = 0, HI = LO = 0 immediately. No commit occurs at cycle 10.
- Edge operands:
  - 0x80000000 div 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
  - mult 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
